// File: rtl/toggle_sync_rx_multi.sv
// Multi-channel toggle receiver: sync chain -> edge pulse -> saturating pending counter with pop handshake.
// Latency: edge sampled at E pulses after E+SYNC_STAGES-1, counted one cycle later; pop takes effect on valid&ready.
// Backpressure: events queue in the counter up to 2^CNT_W-1; TOGGLE_SYNC_RX_OVF_EN adds sticky ovf_o on drops.
module toggle_sync_rx_multi #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic [CH_NUM-1:0]       toggle_i,
  output logic [CH_NUM-1:0]       pulse_o,
  output logic [CH_NUM-1:0]       evt_valid_o,
  input  logic [CH_NUM-1:0]       evt_ready_i,
  output logic [CH_NUM*CNT_W-1:0] evt_cnt_o,
  output logic [CH_NUM-1:0]       ovf_o
);

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    (* ASYNC_REG = "true" *) logic meta_q;
    logic [SYNC_STAGES-2:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   inc;
    logic                   pop;
    logic                   at_max;

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        meta_q <= 1'b0;
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        meta_q    <= toggle_i[n];
        sync_q[0] <= meta_q;
        for (int k = 1; k < SYNC_STAGES - 1; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
        hist_q <= sync_q[SYNC_STAGES-2];
      end
    end

    assign inc    = sync_q[SYNC_STAGES-2] ^ hist_q;
    assign at_max = (cnt_q == '1);
    assign pop    = evt_valid_o[n] & evt_ready_i[n];

    // Coincident inc and pop cancel, so a full counter that is being drained never drops.
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        cnt_q <= '0;
      end else if (inc && !pop && !at_max) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!inc && pop) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end

    assign pulse_o[n]                   = inc;
    assign evt_valid_o[n]               = (cnt_q != '0);
    assign evt_cnt_o[n*CNT_W +: CNT_W]  = cnt_q;

`ifdef TOGGLE_SYNC_RX_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        ovf_q <= 1'b0;
      end else if (inc && !pop && at_max) begin
        ovf_q <= 1'b1;
      end
    end
    assign ovf_o[n] = ovf_q;
`else
    assign ovf_o[n] = 1'b0;
`endif
  end

endmodule
